seq_divider: RTL and testbench

- Multi-cycle integer divider for the execute stage: iterative restoring division, one shift-and-subtract step per cycle.
- Complements the single-cycle combinational adder. The pipeline issues div/rem operations through a valid/ready request port and stalls until the result handshake completes.
- Supports signed and unsigned operands with RISC-V M-extension corner-case semantics.

---
 rtl/cpu_alu_pkg.sv | 15 +
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 171 +++++++++++++++++
 tb/tb_seq_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: default datapath width, divider FSM states, divider corner-case constants.
package cpu_alu_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [DATA_W-1:0] DIV0_QUOTIENT = '1;
    localparam logic [DATA_W-1:0] SIGNED_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract |divisor|, keep or restore.
// Combinational, no flow control; this is the only subtractor in the iteration path.
module div_step #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_bit,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // The partial remainder is always below the divisor, so a set carry-out bit of the
    // shift already guarantees the subtraction succeeds; the difference then fits DATA_W bits.
    always_comb begin
        shifted = {i_rem, i_bit};
        trial   = {1'b0, shifted[DATA_W-1:0]} - {1'b0, i_divisor};
        o_q_bit = shifted[DATA_W] | ~trial[DATA_W];
        o_rem   = o_q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider with RISC-V corner cases; valid/ready on request and result.
// Latency DATA_W cycles (1 for divide-by-zero / overflow); result held in DONE until i_ready.
module seq_divider #(
    parameter int DATA_W = cpu_alu_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_div_by_zero
);
    import cpu_alu_pkg::*;

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] div_q, div_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              spec_dbz_q, spec_dbz_d;
    logic              spec_ovf_q, spec_ovf_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              dbz_q, dbz_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] step_rem;
    logic              step_bit;
    logic [DATA_W-1:0] q_next;
    logic              dvd_neg;
    logic              dvs_neg;

    div_step #(.DATA_W(DATA_W)) u_step (
        .i_rem     (r_q),
        .i_bit     (q_q[DATA_W-1]),
        .i_divisor (div_q),
        .o_rem     (step_rem),
        .o_q_bit   (step_bit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        div_d      = div_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        spec_dbz_d = spec_dbz_q;
        spec_ovf_d = spec_ovf_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        q_next     = {q_q[DATA_W-2:0], step_bit};
        dvd_neg    = i_signed & i_dividend[DATA_W-1];
        dvs_neg    = i_signed & i_divisor[DATA_W-1];

        case (state_q)
            DIV_IDLE: begin
                if (i_valid) begin
                    state_d    = DIV_RUN;
                    r_d        = '0;
                    spec_dbz_d = 1'b0;
                    spec_ovf_d = 1'b0;
                    // Corner cases spend one RUN cycle so their result lands one edge after acceptance.
                    if (i_divisor == '0) begin
                        spec_dbz_d = 1'b1;
                        cnt_d      = CNT_W'(1);
                        q_d        = i_dividend;
                    end else if (i_signed && i_dividend == MIN_NEG && i_divisor == ALL_ONES) begin
                        spec_ovf_d = 1'b1;
                        cnt_d      = CNT_W'(1);
                        q_d        = i_dividend;
                    end else begin
                        cnt_d     = CNT_W'(DATA_W);
                        q_d       = dvd_neg ? -i_dividend : i_dividend;
                        div_d     = dvs_neg ? -i_divisor : i_divisor;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                    end
                end
            end
            DIV_RUN: begin
                if (spec_dbz_q) begin
                    quo_d   = ALL_ONES;
                    rem_d   = q_q;
                    dbz_d   = 1'b1;
                    state_d = DIV_DONE;
                end else if (spec_ovf_q) begin
                    quo_d   = q_q;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = DIV_DONE;
                end else begin
                    r_d   = step_rem;
                    q_d   = q_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quo_d   = neg_quo_q ? -q_next : q_next;
                        rem_d   = neg_rem_q ? -step_rem : step_rem;
                        dbz_d   = 1'b0;
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                if (i_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        ready_d = (state_d == DIV_IDLE);
        valid_d = (state_d == DIV_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= '0;
            div_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_dbz_q <= 1'b0;
            spec_ovf_q <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            div_q      <= div_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            spec_dbz_q <= spec_dbz_d;
            spec_ovf_q <= spec_ovf_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_valid       = valid_q;
    assign o_quotient    = quo_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboarded bench for seq_divider: reference division model, latency, backpressure and reset abort.
module tb_seq_divider;

    localparam int W = 64;
    localparam int TIMEOUT = 300;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic         i_signed;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    seq_divider #(.DATA_W(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_signed      (i_signed),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dbz = 1'b0;
        e.lat = 1;
        if (b == '0) begin
            e.quo = '1;
            e.rem = a;
            e.dbz = 1'b1;
        end else if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            e.quo = a;
            e.rem = '0;
        end else if (sgn) begin
            e.quo = $signed(a) / $signed(b);
            e.rem = $signed(a) % $signed(b);
            e.lat = W;
        end else begin
            e.quo = a / b;
            e.rem = a % b;
            e.lat = W;
        end
        return e;
    endfunction

    // Drives one request on the negedge, accepted at the next posedge; inputs are scrambled afterwards.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!o_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_before_issue", {63'b0, o_ready}, 64'd1);
        sb.push_back(model(sgn, a, b));
        i_valid    = 1'b1;
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        @(posedge clk);
        @(negedge clk);
        i_valid    = 1'b0;
        i_signed   = ~sgn;
        i_dividend = ~a;
        i_divisor  = ~b;
    endtask

    task automatic wait_result(input string tag);
        int   cyc = 0;
        exp_t e;
        while (!o_valid && cyc < TIMEOUT) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check_val({tag, "_lat"}, 64'(cyc), 64'(e.lat));
        check_val({tag, "_quo"}, o_quotient, e.quo);
        check_val({tag, "_rem"}, o_remainder, e.rem);
        check_val({tag, "_dbz"}, {63'b0, o_div_by_zero}, {63'b0, e.dbz});
        check_val({tag, "_rdy_low"}, {63'b0, o_ready}, 64'd0);
    endtask

    task automatic consume(input string tag);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_vld_drop"}, {63'b0, o_valid}, 64'd0);
        check_val({tag, "_rdy_rise"}, {63'b0, o_ready}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(sgn, a, b);
        wait_result(tag);
        consume(tag);
    endtask

    logic [W-1:0] hold_q, hold_r;
    logic         hold_z;

    initial begin
        rst        = 1'b1;
        i_valid    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 64'd9;
        i_divisor  = 64'd3;
        i_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {63'b0, o_ready}, 64'd1);
        check_val("rst_valid", {63'b0, o_valid}, 64'd0);
        check_val("rst_quo", o_quotient, 64'd0);
        check_val("rst_rem", o_remainder, 64'd0);
        check_val("rst_dbz", {63'b0, o_div_by_zero}, 64'd0);
        i_valid = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        run_op("u100_7", 1'b0, 64'd100, 64'd7);
        run_op("s_m7_2", 1'b1, -64'sd7, 64'd2);
        run_op("s_7_m2", 1'b1, 64'd7, -64'sd2);
        run_op("s_m7_m2", 1'b1, -64'sd7, -64'sd2);
        run_op("u_ones", 1'b0, '1, '1);
        run_op("u_big_ones", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, '1);
        run_op("s5_0", 1'b1, 64'd5, 64'd0);
        run_op("u5_0", 1'b0, 64'd5, 64'd0);
        run_op("s_min_m1", 1'b1, 64'h8000_0000_0000_0000, '1);
        run_op("u_min_m1", 1'b0, 64'h8000_0000_0000_0000, '1);
        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] a, b;
            a = {$urandom, $urandom};
            b = (k % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            run_op($sformatf("rnd%0d", k), 1'(k % 3 == 0), a, b);
        end

        // Backpressure: result must hold while i_ready is low and new requests are dropped.
        i_ready = 1'b0;
        issue(1'b0, 64'd200, 64'd9);
        wait_result("bp");
        hold_q = o_quotient;
        hold_r = o_remainder;
        hold_z = o_div_by_zero;
        i_valid    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 64'd77;
        i_divisor  = 64'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("bp_quo%0d", k), o_quotient, hold_q);
            check_val($sformatf("bp_rem%0d", k), o_remainder, hold_r);
            check_val($sformatf("bp_dbz%0d", k), {63'b0, o_div_by_zero}, {63'b0, hold_z});
            check_val($sformatf("bp_vld%0d", k), {63'b0, o_valid}, 64'd1);
            check_val($sformatf("bp_rdy%0d", k), {63'b0, o_ready}, 64'd0);
        end
        i_valid = 1'b0;
        consume("bp");
        repeat (3) begin
            @(negedge clk);
            check_val("bp_not_queued", {63'b0, o_valid}, 64'd0);
        end
        run_op("u50_5", 1'b0, 64'd50, 64'd5);

        // Reset during iteration 20 aborts the operation immediately.
        issue(1'b0, 64'd123456789, 64'd321);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_vld", {63'b0, o_valid}, 64'd0);
        check_val("abort_rdy", {63'b0, o_ready}, 64'd1);
        check_val("abort_quo", o_quotient, 64'd0);
        check_val("abort_rem", o_remainder, 64'd0);
        sb.delete();
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_hold_vld", {63'b0, o_valid}, 64'd0);
        i_valid = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        run_op("u1000_33", 1'b0, 64'd1000, 64'd33);

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
